// File: rtl/rx_packet_reader.sv
// Reads each completed page from the receiver's ping-pong sample RAM and streams
// it as a framed byte sequence (8-byte header + 6*WORDS payload bytes).
module rx_packet_reader #(
  parameter int          WORDS = 82,
  parameter logic [7:0]  SYNC0 = 8'hEF,
  parameter logic [7:0]  SYNC1 = 8'hFE,
  parameter logic [7:0]  PTYPE = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_block,
  output logic [7:0]  rd_addr,
  input  logic [47:0] rd_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam logic [6:0] LAST_W  = 7'(WORDS - 1);
  localparam logic [7:0] WORDS_B = 8'(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  state_t      state_q, state_d;
  logic        blk_q;
  logic        page_q, page_d;
  logic [6:0]  addr_w_q, addr_w_d;
  logic [6:0]  cur_w_q, cur_w_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [47:0] shift_q, shift_d;
  logic [31:0] seq_q, seq_d;
  logic        pend_q, pend_d;
  logic        pend_page_q, pend_page_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        toggle;
  logic        start;
  logic        start_page;
  logic        toggle_taken;

  assign toggle      = mem_block ^ blk_q;
  assign rd_addr     = {page_q, addr_w_q};
  assign overrun_cnt = ovr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      blk_q       <= mem_block;
      page_q      <= 1'b0;
      addr_w_q    <= '0;
      cur_w_q     <= '0;
      hcnt_q      <= '0;
      bcnt_q      <= '0;
      phase_q     <= '0;
      shift_q     <= '0;
      seq_q       <= '0;
      pend_q      <= 1'b0;
      pend_page_q <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= mem_block;
      page_q      <= page_d;
      addr_w_q    <= addr_w_d;
      cur_w_q     <= cur_w_d;
      hcnt_q      <= hcnt_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      seq_q       <= seq_d;
      pend_q      <= pend_d;
      pend_page_q <= pend_page_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    addr_w_d     = addr_w_q;
    cur_w_d      = cur_w_q;
    hcnt_d       = hcnt_q;
    bcnt_d       = bcnt_q;
    phase_d      = phase_q;
    shift_d      = shift_q;
    seq_d        = seq_q;
    pend_d       = pend_q;
    pend_page_d  = pend_page_q;
    ovr_d        = ovr_q;
    start        = 1'b0;
    start_page   = mem_block;
    toggle_taken = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (toggle) begin
          start        = 1'b1;
          toggle_taken = 1'b1;
        end
      end
      S_HDR: begin
        // Word 0 is read during the header: address it, then capture it a cycle later.
        if (phase_q == 2'd0) begin
          addr_w_d = 7'd1;
          phase_d  = 2'd1;
        end else if (phase_q == 2'd1) begin
          shift_d = rd_data;
          phase_d = 2'd2;
        end
        if (out_ready) begin
          hcnt_d = hcnt_q + 3'd1;
          if (hcnt_q == 3'd7) state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (out_ready) begin
          shift_d = {shift_q[39:0], 8'h00};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd5) begin
            bcnt_d = '0;
            if (cur_w_q == LAST_W) begin
              seq_d = seq_q + 32'd1;
              if (pend_q) begin
                start       = 1'b1;
                start_page  = pend_page_q;
                pend_d      = 1'b0;
              end else if (toggle) begin
                start        = 1'b1;
                toggle_taken = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              shift_d = rd_data;
              cur_w_d = cur_w_q + 7'd1;
              if (addr_w_q < LAST_W) addr_w_d = addr_w_q + 7'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after any pending consumption at frame end.
    if (toggle && !toggle_taken) begin
      if (!pend_d) begin
        pend_d      = 1'b1;
        pend_page_d = mem_block;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end

    if (start) begin
      state_d  = S_HDR;
      page_d   = start_page;
      addr_w_d = '0;
      cur_w_d  = '0;
      hcnt_d   = '0;
      bcnt_d   = '0;
      phase_d  = '0;
    end
  end

  always_comb begin
    out_valid = (state_q != S_IDLE);
    busy      = (state_q != S_IDLE);
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      S_HDR: begin
        case (hcnt_q)
          3'd0:    out_data = SYNC0;
          3'd1:    out_data = SYNC1;
          3'd2:    out_data = PTYPE;
          3'd3:    out_data = WORDS_B;
          3'd4:    out_data = seq_q[31:24];
          3'd5:    out_data = seq_q[23:16];
          3'd6:    out_data = seq_q[15:8];
          default: out_data = seq_q[7:0];
        endcase
      end
      S_PAY: begin
        out_data = shift_q[47:40];
        out_last = (bcnt_q == 3'd5) && (cur_w_q == LAST_W);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rx_packet_reader.sv
// Bench for rx_packet_reader: RAM model, byte monitor and a frame-level reference
// that builds expected byte streams directly from page contents and sequence numbers.
module tb_rx_packet_reader;

  localparam int WORDS = 82;
  localparam int FLEN  = 6 * WORDS + 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_block;
  logic        out_ready;
  logic [7:0]  rd_addr;
  logic [47:0] rd_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic [7:0]  overrun_cnt;

  logic [47:0] mem [256];

  rx_packet_reader #(.WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .mem_block(mem_block), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         valid_cycles = 0;
  int         stall_viol = 0;
  int         addr_viol = 0;
  int         first_bad = -1;
  bit         rand_ready = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    if (int'(rd_addr[6:0]) > WORDS - 1) addr_viol++;
    if (out_valid) valid_cycles++;
    if (prev_stall && !reset && (!out_valid || out_data !== prev_data)) stall_viol++;
    if (out_valid && out_ready) acc_q.push_back('{out_data, out_last, cyc});
    prev_stall = out_valid && !out_ready && !reset;
    prev_data  = out_data;
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input logic mb);
    step();
    reset = 1'b1;
    mem_block = mb;
    step();
    step();
    reset = 1'b0;
    rand_ready = 0;
    acc_q.delete();
    exp_q.delete();
    valid_cycles = 0;
    stall_viol = 0;
  endtask

  // Reference frame: header fields then each word MSB byte first.
  task automatic append_frame(input logic pg, input logic [31:0] s);
    logic [47:0] w48;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(WORDS));
    exp_q.push_back(s[31:24]);
    exp_q.push_back(s[23:16]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    for (int w = 0; w < WORDS; w++) begin
      w48 = mem[{pg, 7'(w)}];
      for (int b = 0; b < 6; b++) exp_q.push_back(w48[47 - 8*b -: 8]);
    end
  endtask

  function automatic int count_diff(input int n);
    int nd = 0;
    first_bad = -1;
    for (int i = 0; i < n; i++) begin
      logic exp_l;
      exp_l = ((i % FLEN) == FLEN - 1);
      if (i >= acc_q.size() || i >= exp_q.size() ||
          acc_q[i].d !== exp_q[i] || acc_q[i].l !== exp_l) begin
        nd++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return nd;
  endfunction

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (acc_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, acc_q.size(), n);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    if (out_last !== 1'b0)     begin errors++; $display("FAIL rst_last: got %b required 0", out_last); end
    if (out_data !== 8'h00)    begin errors++; $display("FAIL rst_data: got %h required 00", out_data); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (rd_addr !== 8'h00)     begin errors++; $display("FAIL rst_addr: got %h required 00", rd_addr); end
    if (overrun_cnt !== 8'h00) begin errors++; $display("FAIL rst_ovr: got %0d required 0", overrun_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int t0;
    int nd;
    for (int k = 0; k < WORDS; k++) mem[{1'b1, 7'(k)}] = {8'(k), 40'h0};
    out_ready = 1'b1;
    step();
    mem_block = 1'b1;
    t0 = cyc;
    append_frame(1'b1, 32'd0);
    wait_bytes(FLEN, FLEN + 50, "single");
    repeat (20) step();
    nd = count_diff(FLEN);
    checks += 5;
    if (acc_q.size() !== FLEN) begin errors++; $display("FAIL single_len: got %0d required %0d", acc_q.size(), FLEN); end
    if (nd !== 0) begin errors++; $display("FAIL single_bytes: got %0d bad bytes (first %0d) required 0", nd, first_bad); end
    if (acc_q.size() > 0 && acc_q[0].c !== t0 + 1) begin errors++; $display("FAIL single_latency: got cycle %0d required %0d", acc_q[0].c, t0 + 1); end
    if (acc_q.size() >= FLEN && acc_q[FLEN-1].c - acc_q[0].c + 1 !== FLEN) begin
      errors++; $display("FAIL single_span: got %0d cycles required %0d", acc_q[FLEN-1].c - acc_q[0].c + 1, FLEN);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", busy); end
    $display("test_single: %0d bytes, first at cycle %0d", acc_q.size(), t0 + 1);
  endtask

  task automatic test_backpressure();
    int nd;
    for (int a = 0; a < 256; a++) mem[a] = 48'({$urandom, $urandom});
    do_reset(mem_block);
    rand_ready = 1;
    for (int f = 0; f < 3; f++) begin
      step();
      mem_block = ~mem_block;
      append_frame(mem_block, 32'(f));
      wait_bytes(FLEN * (f + 1), FLEN * 6, "bp");
      $display("test_backpressure: frame %0d page %0d accepted", f, mem_block);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (10) step();
    nd = count_diff(3 * FLEN);
    checks += 4;
    if (acc_q.size() !== 3 * FLEN) begin errors++; $display("FAIL bp_len: got %0d required %0d", acc_q.size(), 3 * FLEN); end
    if (nd !== 0) begin errors++; $display("FAIL bp_bytes: got %0d bad bytes (first %0d) required 0", nd, first_bad); end
    if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d violations required 0", stall_viol); end
    if (acc_q.size() > 2 * FLEN + 7 && acc_q[2 * FLEN + 7].d !== 8'd2) begin
      errors++; $display("FAIL bp_seq2: got %0d required 2", acc_q[2 * FLEN + 7].d);
    end
  endtask

  task automatic test_pending_overrun();
    int nd;
    do_reset(mem_block);
    out_ready = 1'b1;
    step();
    mem_block = ~mem_block;
    append_frame(mem_block, 32'd0);
    repeat (20) step();
    mem_block = ~mem_block;
    append_frame(mem_block, 32'd1);
    repeat (20) step();
    mem_block = ~mem_block;
    wait_bytes(2 * FLEN, 2 * FLEN + 100, "pend");
    repeat (30) step();
    nd = count_diff(2 * FLEN);
    checks += 5;
    if (acc_q.size() !== 2 * FLEN) begin errors++; $display("FAIL pend_len: got %0d required %0d", acc_q.size(), 2 * FLEN); end
    if (nd !== 0) begin errors++; $display("FAIL pend_bytes: got %0d bad bytes (first %0d) required 0", nd, first_bad); end
    if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL pend_overrun: got %0d required 1", overrun_cnt); end
    if (acc_q.size() > FLEN && acc_q[FLEN].c !== acc_q[FLEN-1].c + 1) begin
      errors++; $display("FAIL pend_b2b: got cycle %0d required %0d", acc_q[FLEN].c, acc_q[FLEN-1].c + 1);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL pend_busy_end: got %b required 0", busy); end
    $display("test_pending_overrun: %0d bytes, overrun_cnt=%0d", acc_q.size(), overrun_cnt);
  endtask

  task automatic test_coincident();
    int t0;
    int nd;
    do_reset(mem_block);
    out_ready = 1'b1;
    step();
    mem_block = ~mem_block;
    t0 = cyc;
    append_frame(mem_block, 32'd0);
    repeat (10) step();
    mem_block = ~mem_block;
    append_frame(mem_block, 32'd1);
    repeat (FLEN - 10) step();
    mem_block = ~mem_block;
    append_frame(mem_block, 32'd2);
    wait_bytes(3 * FLEN, 3 * FLEN + 100, "coinc");
    repeat (10) step();
    nd = count_diff(3 * FLEN);
    checks += 5;
    if (acc_q.size() !== 3 * FLEN) begin errors++; $display("FAIL coinc_len: got %0d required %0d", acc_q.size(), 3 * FLEN); end
    if (nd !== 0) begin errors++; $display("FAIL coinc_bytes: got %0d bad bytes (first %0d) required 0", nd, first_bad); end
    if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL coinc_overrun: got %0d required 0", overrun_cnt); end
    if (acc_q.size() >= FLEN && acc_q[FLEN-1].c !== t0 + FLEN) begin
      errors++; $display("FAIL coinc_last_cycle: got %0d required %0d", acc_q[FLEN-1].c, t0 + FLEN);
    end
    if (acc_q.size() > 2 * FLEN && acc_q[2 * FLEN].c !== t0 + 2 * FLEN + 1) begin
      errors++; $display("FAIL coinc_third_start: got %0d required %0d", acc_q[2 * FLEN].c, t0 + 2 * FLEN + 1);
    end
    $display("test_coincident: %0d bytes, overrun_cnt=%0d", acc_q.size(), overrun_cnt);
  endtask

  task automatic test_reset_midframe();
    int nd;
    int lasts = 0;
    int n_after;
    do_reset(mem_block);
    out_ready = 1'b1;
    step();
    mem_block = ~mem_block;
    append_frame(mem_block, 32'd0);
    repeat (20) step();
    mem_block = ~mem_block;
    repeat (20) step();
    mem_block = ~mem_block;
    wait_bytes(200, 400, "mid");
    checks++;
    if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre_overrun: got %0d required 1", overrun_cnt); end
    nd = count_diff(200);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL mid_prefix: got %0d bad bytes (first %0d) required 0", nd, first_bad); end
    reset = 1'b1;
    step();
    checks += 3;
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL mid_valid: got %b required 0", out_valid); end
    if (overrun_cnt !== 8'd0)  begin errors++; $display("FAIL mid_overrun: got %0d required 0", overrun_cnt); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
    reset = 1'b0;
    n_after = acc_q.size();
    repeat (40) step();
    foreach (acc_q[i]) if (acc_q[i].l) lasts++;
    checks += 2;
    if (lasts !== 0) begin errors++; $display("FAIL mid_no_last: got %0d last bytes required 0", lasts); end
    if (acc_q.size() !== n_after) begin errors++; $display("FAIL mid_pending_cleared: got %0d bytes required %0d", acc_q.size(), n_after); end
    acc_q.delete();
    exp_q.delete();
    step();
    mem_block = ~mem_block;
    append_frame(mem_block, 32'd0);
    wait_bytes(FLEN, FLEN + 50, "mid_next");
    nd = count_diff(FLEN);
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL mid_next_bytes: got %0d bad bytes (first %0d) required 0", nd, first_bad); end
    $display("test_reset_midframe: post-reset frame %0d bytes", acc_q.size());
  endtask

  task automatic test_const_block();
    do_reset(1'b1);
    out_ready = 1'b1;
    repeat (100) step();
    checks += 3;
    if (valid_cycles !== 0)    begin errors++; $display("FAIL const_no_output: got %0d valid cycles required 0", valid_cycles); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL const_busy: got %b required 0", busy); end
    if (overrun_cnt !== 8'd0)  begin errors++; $display("FAIL const_overrun: got %0d required 0", overrun_cnt); end
    checks++;
    if (addr_viol !== 0) begin errors++; $display("FAIL addr_range: got %0d out-of-range addresses required 0", addr_viol); end
    $display("test_const_block: valid cycles %0d", valid_cycles);
  endtask

  initial begin
    reset = 1'b1;
    mem_block = 1'b0;
    out_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    do_reset(1'b0);
    test_reset();
    test_single();
    test_backpressure();
    test_pending_overrun();
    test_coincident();
    test_reset_midframe();
    test_const_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
